// File: rtl/cheat_pkg.sv
// Cheat engine shared definitions.
// Register map, CMP field layout and slot record.
package cheat_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SLOT   = 3'd1;
  localparam logic [2:0] REG_ADDR   = 3'd2;
  localparam logic [2:0] REG_CMP    = 3'd3;
  localparam logic [2:0] REG_REPL   = 3'd4;
  localparam logic [2:0] REG_COMMIT = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  localparam int CMP_EN_BIT  = 8;
  localparam int CMP_VAL_LSB = 0;

  localparam int SLOT_ADDR_W = 32;
  localparam int SLOT_DATA_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] addr;
    logic                   cmp_en;
    logic [SLOT_DATA_W-1:0] cmp_val;
    logic [SLOT_DATA_W-1:0] repl;
  } cheat_slot_t;

endpackage

// File: rtl/cheat_prio_enc.sv
// Lowest-index priority encoder.
// Reports whether any bit is set and the index of the lowest one.
module cheat_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] hit_vec,
  output logic         hit_any,
  output logic [W-1:0] hit_idx
);

  // scan downward so the lowest set bit is the last writer
  always_comb begin
    hit_any = |hit_vec;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = W'(i);
    end
  end

endmodule

// File: rtl/cheat_engine_n.sv
// N-slot cheat engine on the SRAM read path.
// Wishbone staged-write/commit programming, 1-cycle lookup.
module cheat_engine_n
  import cheat_pkg::*;
#(
  parameter  int NUM_CHEATS = 16,
  parameter  int ADDR_W     = 24,
  parameter  int DATA_W     = 8,
  localparam int IDX_W      = $clog2(NUM_CHEATS)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cheats_enabled,
  input  logic              i_lookup_valid,
  input  logic [ADDR_W-1:0] i_sram_address,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic              o_valid,
  output logic              o_cheat_stb,
  output logic [DATA_W-1:0] o_sram_data,
  output logic [IDX_W-1:0]  o_hit_idx,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [2:0]        i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic [31:0]       o_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall
);

  localparam int SLOT_W = IDX_W + 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam logic [SLOT_W-1:0] NUM_L =
    SLOT_W'(NUM_CHEATS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_CHEATS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  sweep;
  logic              en;
  logic              err;
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] stg_slot;
  logic [ADDR_W-1:0] stg_addr;
  logic              stg_cmp_en;
  logic [DATA_W-1:0] stg_cmp_val;
  logic [DATA_W-1:0] stg_repl;
  cheat_slot_t       slots [NUM_CHEATS];

  logic                   busy;
  logic                   acc;
  logic                   wr;
  logic                   slot_ok;
  logic [IDX_W-1:0]       widx;
  cheat_slot_t            stg_new;
  logic [31:0]            rd_data;
  logic [NUM_CHEATS-1:0]  hit;
  logic                   hit_any;
  logic [IDX_W-1:0]       win;
  logic                   stb;
  logic [SLOT_ADDR_W-1:0] look_addr;
  logic [SLOT_DATA_W-1:0] look_data;
  logic                   unused_wb;

  assign busy       = (state == S_CLEAR);
  assign o_wb_stall = busy;
  assign acc        = i_wb_cyc & i_wb_stb & ~busy;
  assign wr         = acc & i_wb_we;
  assign slot_ok    = (stg_slot < NUM_L);
  assign widx       = stg_slot[IDX_W-1:0];
  assign look_addr  = SLOT_ADDR_W'(i_sram_address);
  assign look_data  = SLOT_DATA_W'(i_sram_data);
  assign unused_wb  = ^i_wb_data;

  // slot image built from the staging registers
  always_comb begin
    stg_new         = '0;
    stg_new.valid   = 1'b1;
    stg_new.addr    = SLOT_ADDR_W'(stg_addr);
    stg_new.cmp_en  = stg_cmp_en;
    stg_new.cmp_val = SLOT_DATA_W'(stg_cmp_val);
    stg_new.repl    = SLOT_DATA_W'(stg_repl);
  end

  // register readback mux
  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      REG_CTRL:   rd_data[0] = en;
      REG_SLOT:   rd_data = 32'(stg_slot);
      REG_ADDR:   rd_data = 32'(stg_addr);
      REG_CMP: begin
        rd_data[CMP_EN_BIT] = stg_cmp_en;
        rd_data[CMP_VAL_LSB +: DATA_W] = stg_cmp_val;
      end
      REG_REPL:   rd_data = 32'(stg_repl);
      REG_STATUS: begin
        rd_data[0]    = busy;
        rd_data[1]    = err;
        rd_data[15:8] = 8'(cnt);
      end
      default:    rd_data = '0;
    endcase
  end

  // per-slot match against the current bus cycle
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CHEATS; i++) begin
      hit[i] = slots[i].valid
             & (slots[i].addr == look_addr)
             & (~slots[i].cmp_en
                | (slots[i].cmp_val == look_data));
    end
  end

  cheat_prio_enc #(
    .N (NUM_CHEATS),
    .W (IDX_W)
  ) u_enc (
    .hit_vec (hit),
    .hit_any (hit_any),
    .hit_idx (win)
  );

  assign stb = i_lookup_valid & i_cheats_enabled
             & en & ~busy & hit_any;

  // control FSM, staging, slot table and count
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      sweep       <= '0;
      en          <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
      stg_slot    <= '0;
      stg_addr    <= '0;
      stg_cmp_en  <= 1'b0;
      stg_cmp_val <= '0;
      stg_repl    <= '0;
      for (int i = 0; i < NUM_CHEATS; i++) begin
        slots[i] <= '0;
      end
    end else if (busy) begin
      slots[sweep].valid <= 1'b0;
      if (slots[sweep].valid) cnt <= cnt - 1'b1;
      sweep <= sweep + 1'b1;
      if (sweep == LAST) begin
        state <= S_IDLE;
        sweep <= '0;
      end
    end else if (wr) begin
      unique case (1'b1)
        (i_wb_addr == REG_CTRL): begin
          en <= i_wb_data[0];
          if (i_wb_data[1]) begin
            state <= S_CLEAR;
            sweep <= '0;
          end
        end
        (i_wb_addr == REG_SLOT):
          stg_slot <= i_wb_data[SLOT_W-1:0];
        (i_wb_addr == REG_ADDR):
          stg_addr <= i_wb_data[ADDR_W-1:0];
        (i_wb_addr == REG_CMP): begin
          stg_cmp_en  <= i_wb_data[CMP_EN_BIT];
          stg_cmp_val <= i_wb_data[CMP_VAL_LSB +: DATA_W];
        end
        (i_wb_addr == REG_REPL):
          stg_repl <= i_wb_data[DATA_W-1:0];
        (i_wb_addr == REG_COMMIT): begin
          if (!slot_ok) begin
            err <= 1'b1;
          end else if (i_wb_data[0]) begin
            slots[widx] <= stg_new;
            if (!slots[widx].valid) cnt <= cnt + 1'b1;
          end else begin
            slots[widx].valid <= 1'b0;
            if (slots[widx].valid) cnt <= cnt - 1'b1;
          end
        end
        (i_wb_addr == REG_STATUS):
          if (i_wb_data[1]) err <= 1'b0;
        default: ;
      endcase
    end
  end

  // registered lookup result
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid     <= 1'b0;
      o_cheat_stb <= 1'b0;
      o_sram_data <= '0;
      o_hit_idx   <= '0;
    end else begin
      o_valid     <= i_lookup_valid;
      o_cheat_stb <= stb;
      o_sram_data <= stb ? DATA_W'(slots[win].repl)
                         : i_sram_data;
      o_hit_idx   <= win;
    end
  end

  // wishbone ack and read data, one cycle after accept
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= acc;
      if (acc) o_wb_data <= i_wb_we ? '0 : rd_data;
    end
  end

endmodule

// File: tb/tb_cheat_engine_n.sv
// Self-checking bench for cheat_engine_n.
// Directed scenarios plus randomized lookups against a slot-table model.
module tb_cheat_engine_n;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cheats_en;
  logic        lv;
  logic [23:0] la;
  logic [7:0]  ld;
  logic        o_valid;
  logic        o_cheat_stb;
  logic [7:0]  o_sram_data;
  logic [3:0]  o_hit_idx;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  wa;
  logic [31:0] wd;
  logic [31:0] o_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;

  int checks = 0;
  int failures = 0;

  bit m_valid [N];
  int m_addr [N];
  bit m_cmpen [N];
  int m_cmpval [N];
  int m_repl [N];
  bit m_en;
  bit m_err;
  int s_slot, s_addr, s_cmpval, s_repl;
  bit s_cmpen;
  bit last_ack;

  logic       g_valid, g_stb;
  logic [7:0] g_data;
  logic [3:0] g_idx;

  always #5 clk = ~clk;

  cheat_engine_n dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_cheats_enabled (cheats_en),
    .i_lookup_valid   (lv),
    .i_sram_address   (la),
    .i_sram_data      (ld),
    .o_valid          (o_valid),
    .o_cheat_stb      (o_cheat_stb),
    .o_sram_data      (o_sram_data),
    .o_hit_idx        (o_hit_idx),
    .i_wb_cyc         (cyc),
    .i_wb_stb         (stb),
    .i_wb_we          (we),
    .i_wb_addr        (wa),
    .i_wb_data        (wd),
    .o_wb_data        (o_wb_data),
    .o_wb_ack         (o_wb_ack),
    .o_wb_stall       (o_wb_stall)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[i];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_en = 0; m_err = 0;
    s_slot = 0; s_addr = 0; s_cmpen = 0;
    s_cmpval = 0; s_repl = 0;
  endtask

  task automatic model_apply(input logic [2:0] a,
                             input logic [31:0] d);
    case (a)
      3'd0: begin
        m_en = d[0];
        if (d[1]) for (int i = 0; i < N; i++) m_valid[i] = 0;
      end
      3'd1: s_slot = int'(d[7:0]);
      3'd2: s_addr = int'(d[23:0]);
      3'd3: begin s_cmpen = d[8]; s_cmpval = int'(d[7:0]); end
      3'd4: s_repl = int'(d[7:0]);
      3'd5: begin
        if (s_slot >= N) m_err = 1;
        else if (d[0]) begin
          m_valid[s_slot] = 1; m_addr[s_slot] = s_addr;
          m_cmpen[s_slot] = s_cmpen;
          m_cmpval[s_slot] = s_cmpval; m_repl[s_slot] = s_repl;
        end else m_valid[s_slot] = 0;
      end
      3'd6: if (d[1]) m_err = 0;
      default: ;
    endcase
  endtask

  task automatic model_lookup(input int a, input int d,
                              output logic e_stb,
                              output logic [7:0] e_data,
                              output logic [3:0] e_idx);
    int w = -1;
    for (int i = 0; i < N; i++) begin
      if (w < 0 && m_valid[i] && m_addr[i] == a &&
          (!m_cmpen[i] || m_cmpval[i] == d)) w = i;
    end
    e_stb  = (w >= 0) && m_en && cheats_en;
    e_data = e_stb ? 8'(m_repl[w]) : 8'(d);
    e_idx  = (w >= 0) ? 4'(w) : 4'd0;
  endtask

  task automatic wb_access(input logic w, input logic [2:0] a,
                           input logic [31:0] d,
                           output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; wa = a; wd = d;
    while (o_wb_stall && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wb_stall_timeout addr=%0d", a);
    end
    @(negedge clk);
    last_ack = o_wb_ack;
    rd = o_wb_data;
    cyc = 0; stb = 0; we = 0;
    if (w) model_apply(a, d);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, dummy);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    wb_access(1'b0, a, 32'd0, d);
  endtask

  task automatic prog_slot(input int s, input int a, input bit ce,
                           input int cv, input int r);
    wb_write(3'd1, 32'(s));
    wb_write(3'd2, 32'(a));
    wb_write(3'd3, {23'd0, ce, 8'(cv)});
    wb_write(3'd4, 32'(r));
    wb_write(3'd5, 32'd1);
  endtask

  task automatic drive_lookup(input int a, input int d);
    @(negedge clk);
    lv = 1; la = 24'(a); ld = 8'(d);
    @(negedge clk);
    g_valid = o_valid; g_stb = o_cheat_stb;
    g_data = o_sram_data; g_idx = o_hit_idx;
    lv = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    apply_reset();
    checks++;
    if ({o_valid, o_cheat_stb, o_sram_data, o_hit_idx,
         o_wb_ack, o_wb_stall, o_wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%b d=%h i=%h a=%b st=%b wd=%h want all 0",
               o_valid, o_cheat_stb, o_sram_data, o_hit_idx,
               o_wb_ack, o_wb_stall, o_wb_data);
    end
    wb_read(3'd6, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL reset_status got=%h want=0", r);
    end
    wb_read(3'd0, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=0", r);
    end
  endtask

  task automatic test_cmp();
    prog_slot(3, 'h0023A2, 1, 'hD6, 'h24);
    wb_write(3'd0, 32'd1);
    drive_lookup('h0023A2, 'hD6);
    checks++;
    if ({g_valid, g_stb, g_data, g_idx} !== {2'b11, 8'h24, 4'd3}) begin
      failures++;
      $display("FAIL cmp_match got v=%b s=%b d=%h i=%0d want 1 1 24 3",
               g_valid, g_stb, g_data, g_idx);
    end
    drive_lookup('h0023A2, 'hD5);
    checks++;
    if ({g_valid, g_stb, g_data} !== {2'b10, 8'hD5}) begin
      failures++;
      $display("FAIL cmp_miss got v=%b s=%b d=%h want 1 0 d5",
               g_valid, g_stb, g_data);
    end
    wb_write(3'd3, 32'h0000_00D6);
    wb_write(3'd5, 32'd1);
    drive_lookup('h0023A2, 'hD5);
    checks++;
    if ({g_stb, g_data, g_idx} !== {1'b1, 8'h24, 4'd3}) begin
      failures++;
      $display("FAIL cmp_off got s=%b d=%h i=%0d want 1 24 3",
               g_stb, g_data, g_idx);
    end
  endtask

  task automatic test_priority();
    prog_slot(2, 'h8000, 0, 0, 'h11);
    prog_slot(5, 'h8000, 0, 0, 'h22);
    drive_lookup('h8000, 'h99);
    checks++;
    if ({g_stb, g_data, g_idx} !== {1'b1, 8'h11, 4'd2}) begin
      failures++;
      $display("FAIL prio_low got s=%b d=%h i=%0d want 1 11 2",
               g_stb, g_data, g_idx);
    end
    wb_write(3'd1, 32'd2);
    wb_write(3'd5, 32'd0);
    drive_lookup('h8000, 'h99);
    checks++;
    if ({g_stb, g_data, g_idx} !== {1'b1, 8'h22, 4'd5}) begin
      failures++;
      $display("FAIL prio_inval got s=%b d=%h i=%0d want 1 22 5",
               g_stb, g_data, g_idx);
    end
  endtask

  task automatic test_back_to_back();
    prog_slot(7, 'h4444, 0, 0, 'h33);
    wb_write(3'd4, 32'h44);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; wa = 3'd5; wd = 32'd1;
    lv = 1; la = 24'h4444; ld = 8'h00;
    @(negedge clk);
    checks++;
    if ({o_wb_ack, o_cheat_stb, o_sram_data, o_hit_idx} !==
        {2'b11, 8'h33, 4'd7}) begin
      failures++;
      $display("FAIL b2b_precommit got a=%b s=%b d=%h i=%0d want 1 1 33 7",
               o_wb_ack, o_cheat_stb, o_sram_data, o_hit_idx);
    end
    cyc = 0; stb = 0; we = 0; lv = 0;
    model_apply(3'd5, 32'd1);
    drive_lookup('h4444, 0);
    checks++;
    if ({g_stb, g_data} !== {1'b1, 8'h44}) begin
      failures++;
      $display("FAIL b2b_postcommit got s=%b d=%h want 1 44",
               g_stb, g_data);
    end
  endtask

  task automatic test_error();
    logic [31:0] r;
    int c;
    c = m_count();
    wb_write(3'd1, 32'(N));
    wb_write(3'd5, 32'd1);
    checks++;
    if (last_ack !== 1'b1) begin
      failures++;
      $display("FAIL err_ack got=%b want=1", last_ack);
    end
    wb_read(3'd6, r);
    checks++;
    if (r[1] !== 1'b1 || r[15:8] !== 8'(c)) begin
      failures++;
      $display("FAIL err_status got err=%b cnt=%0d want err=1 cnt=%0d",
               r[1], r[15:8], c);
    end
    wb_write(3'd6, 32'd2);
    wb_read(3'd6, r);
    checks++;
    if (r[1] !== 1'b0 || r[15:8] !== 8'(c)) begin
      failures++;
      $display("FAIL err_clear got err=%b cnt=%0d want err=0 cnt=%0d",
               r[1], r[15:8], c);
    end
  endtask

  task automatic test_random();
    int pool [4] = '{'h100, 'h101, 'h2FFFFF, 'h0};
    int dpool [2] = '{'h5A, 'hA5};
    int r, a, d;
    logic e_stb;
    logic [7:0] e_data;
    logic [3:0] e_idx;
    logic [31:0] st;
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        prog_slot($urandom_range(0, N - 1),
                  pool[$urandom_range(0, 3)],
                  bit'($urandom_range(0, 1)),
                  dpool[$urandom_range(0, 1)],
                  $urandom_range(0, 255));
      end else if (r == 3) begin
        wb_write(3'd1, 32'($urandom_range(0, N - 1)));
        wb_write(3'd5, 32'd0);
      end else if (r == 4) begin
        cheats_en = ($urandom_range(0, 3) != 0);
        wb_write(3'd0, 32'(($urandom_range(0, 3) != 0)));
      end else begin
        a = ($urandom_range(0, 7) == 0) ?
            $urandom_range(0, 'hFFFFFF) : pool[$urandom_range(0, 3)];
        d = ($urandom_range(0, 3) == 0) ?
            $urandom_range(0, 255) : dpool[$urandom_range(0, 1)];
        model_lookup(a, d, e_stb, e_data, e_idx);
        drive_lookup(a, d);
        checks++;
        if ({g_valid, g_stb, g_data, g_idx} !==
            {1'b1, e_stb, e_data, e_idx}) begin
          failures++;
          $display("FAIL rand_lookup a=%h d=%h got s=%b d=%h i=%0d want s=%b d=%h i=%0d",
                   a, d, g_stb, g_data, g_idx, e_stb, e_data, e_idx);
        end
      end
      if (it % 50 == 49) begin
        wb_read(3'd6, st);
        checks++;
        if (st !== {16'd0, 8'(m_count()), 6'd0, m_err, 1'b0}) begin
          failures++;
          $display("FAIL rand_status got=%h want cnt=%0d err=%b",
                   st, m_count(), m_err);
        end
      end
    end
    cheats_en = 1;
    wb_write(3'd0, 32'd1);
  endtask

  task automatic test_clear();
    logic [31:0] r;
    int n;
    prog_slot(10, 'h0ABCDE, 0, 0, 'h77);
    prog_slot(11, 'h0ABCDF, 0, 0, 'h78);
    prog_slot(12, 'h0ABCE0, 1, 'h10, 'h79);
    prog_slot(13, 'h0ABCE1, 0, 0, 'h7A);
    wb_read(3'd6, r);
    checks++;
    if (r[15:8] !== 8'(m_count())) begin
      failures++;
      $display("FAIL clear_precount got=%0d want=%0d",
               r[15:8], m_count());
    end
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; wa = 3'd0; wd = 32'd3;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    n = 0;
    while (o_wb_stall === 1'b1 && n < 200) begin
      if (n == 2) begin
        lv = 1; la = 24'h0ABCDE; ld = 8'h5C;
      end
      if (n == 3) begin
        checks++;
        if ({o_valid, o_cheat_stb, o_sram_data} !==
            {2'b10, 8'h5C}) begin
          failures++;
          $display("FAIL clear_passthru got v=%b s=%b d=%h want 1 0 5c",
                   o_valid, o_cheat_stb, o_sram_data);
        end
        lv = 0;
      end
      @(negedge clk);
      n++;
    end
    model_apply(3'd0, 32'd3);
    checks++;
    if (n != N) begin
      failures++;
      $display("FAIL clear_stall_len got=%0d want=%0d", n, N);
    end
    wb_read(3'd6, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL clear_status got=%h want=0", r);
    end
    drive_lookup('h0ABCDE, 'h5C);
    checks++;
    if ({g_stb, g_data} !== {1'b0, 8'h5C}) begin
      failures++;
      $display("FAIL clear_after got s=%b d=%h want 0 5c",
               g_stb, g_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] r;
    prog_slot(1, 'h1234, 0, 0, 'h99);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; wa = 3'd0; wd = 32'd3;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    repeat (3) @(negedge clk);
    apply_reset();
    checks++;
    if (o_wb_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_clear_stall got=%b want=0", o_wb_stall);
    end
    wb_write(3'd0, 32'd1);
    drive_lookup('h1234, 'h00);
    checks++;
    if ({g_stb, g_data} !== {1'b0, 8'h00}) begin
      failures++;
      $display("FAIL rst_clear_lookup got s=%b d=%h want 0 00",
               g_stb, g_data);
    end
    wb_read(3'd6, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL rst_clear_status got=%h want=0", r);
    end
  endtask

  initial begin
    rst_n = 0; cheats_en = 1; lv = 0; la = '0; ld = '0;
    cyc = 0; stb = 0; we = 0; wa = '0; wd = '0;
    test_reset();
    test_cmp();
    test_priority();
    test_back_to_back();
    test_error();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
